right_shift_sequencer: RTL
==========================

Name: right_shift_sequencer

Overview:
- Multi-cycle controller that produces an N-bit logical right shift by a variable amount.
- Shifts one bit position per clock in a single working register, using the same function as the existing 1-bit registered right logic shifter.
- Start/busy/done handshake. Sits between the ALU operand/control path and the result mux.
- Lets the ALU support shift-by-amount operations without a full barrel shifter.

Parameters:
- N, default 4: operand and result width in bits (N >= 2).
- SW, default $clog2(N)+1: shift-amount width, so that the value N is representable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request a new shift; sampled only when ready=1.
- a  input  N  operand; captured on the accepting edge.
- shamt  input  SW  shift amount; captured on the accepting edge.
- ready  output  1  1 in IDLE and DONE; start is accepted only when ready=1.
- busy  output  1  1 in SHIFT.
- done  output  1  single-cycle pulse in DONE; y is valid from this cycle on.
- y  output  N  result register; holds the last completed result until the next completion.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State returns to IDLE.
  - Working register, counter and y go to 0; done=0, busy=0, ready=1.
  - Reset overrides start and any operation in progress. An aborted operation never produces done, and y is not updated.
- States:
  - IDLE: ready=1. On start=1 go to DONE if the effective amount is 0, otherwise go to SHIFT.
  - SHIFT: busy=1, ready=0. Each edge: work <= {1'b0, work[N-1:1]} and cnt <= cnt-1. The edge on which cnt goes from 1 to 0 also moves to DONE.
  - DONE: done=1, ready=1, lasts one cycle. If start=1, the new operation is accepted in this cycle (same rules as IDLE). Otherwise return to IDLE.
- Capture and clamping:
  - The accepting edge loads work <= a.
  - It loads cnt <= min(shamt, N). Amounts greater than N saturate to N, so the result is all zeros.
- Result register: y <= the final shifted value on the edge that enters DONE.
- Latency:
  - The accepting edge is edge 0.
  - done is high in the cycle after edge max(cnt,0). For amount 0 this is the cycle right after acceptance.
  - Throughput: one operation per (cnt+1) cycles back-to-back.
- start while busy=1 is ignored. It is not queued, and a/shamt are not sampled.
- a and shamt may change freely after acceptance without affecting the operation in progress.
- Only logical shifting is performed: zeros fill from the MSB, and there is no sign extension.

Optional Feature:
- Macro: RIGHT_SHIFT_SEQ_ZERO_SKIP_EN.
- Defined (early termination):
  - On the accepting edge, if a==0, go directly to DONE with y<=0.
  - In SHIFT, if the next work value is 0, go to DONE on that edge regardless of cnt.
  - The result is always identical to the undefined build; only latency shrinks.
- Undefined: latency is exactly the clamped shamt, independent of data.

Test Plan:
- N=4, rst for 1 edge, then a=4'b1000, shamt=2, start for 1 cycle -> busy=1 for 2 cycles; done pulses one cycle after edge 2; y=4'b0010, ready=1.
- a=4'b1011, shamt=0 -> no busy cycle; done in the cycle after acceptance; y=4'b1011.
- a=4'b1111, shamt=7 -> clamped to 4; done after edge 4; y=4'b0000.
- Busy-ignore and back-to-back:
  - a=4'b1100, shamt=3, then hold start=1 with a=4'b0001 during SHIFT -> y=4'b0001 at first done; the request held during SHIFT is ignored.
  - With start still high in DONE, the new a=4'b0001/shamt is accepted on that edge.
- Reset mid-operation: a=4'b1000, shamt=3; rst=1 at edge 2 -> IDLE, y=4'b0000, no done pulse. A subsequent operation completes normally.
- ZERO_SKIP:
  - a=4'b0001, shamt=3 -> with macro, done after edge 1, y=4'b0000.
  - Without macro, done after edge 3, y=4'b0000.

Source files
------------

// File: rtl/right_shift_sequencer.sv
// Multi-cycle logical right shifter: one bit position per clock, start/busy/done handshake.
// Build option: define RIGHT_SHIFT_SEQ_ZERO_SKIP_EN to finish early once the working value is zero.
module right_shift_sequencer #(
  parameter int N  = 4,
  parameter int SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  y
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [SW-1:0] MAX_AMT = SW'(N);
  localparam logic [SW-1:0] ONE     = SW'(1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_work;
  logic [N-1:0]  r_y;
  logic [SW-1:0] r_cnt;

  logic          w_ready;
  logic          w_accept;
  logic [SW-1:0] w_amt;
  logic [N-1:0]  w_next;
  logic          w_last;
  logic          w_skip_in;

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = w_ready && start;

  // Amounts past N saturate; the result is then all zeros anyway.
  assign w_amt  = (shamt > MAX_AMT) ? MAX_AMT : shamt;
  assign w_next = {1'b0, r_work[N-1:1]};

`ifdef RIGHT_SHIFT_SEQ_ZERO_SKIP_EN
  assign w_skip_in = (a == '0);
  assign w_last    = (r_cnt == ONE) || (w_next == '0);
`else
  assign w_skip_in = 1'b0;
  assign w_last    = (r_cnt == ONE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
    end else begin
      unique case (r_state)
        S_SHIFT: begin
          r_work <= w_next;
          r_cnt  <= r_cnt - ONE;
          if (w_last) begin
            r_state <= S_DONE;
            r_y     <= w_next;
          end
        end
        default: begin
          if (w_accept) begin
            r_work <= a;
            r_cnt  <= w_amt;
            // Zero amount (or zero data when skipping) completes immediately.
            if ((w_amt == '0) || w_skip_in) begin
              r_state <= S_DONE;
              r_y     <= a;
            end else begin
              r_state <= S_SHIFT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ready = w_ready;
  assign busy  = (r_state == S_SHIFT);
  assign done  = (r_state == S_DONE);
  assign y     = r_y;

endmodule
